// File: rtl/regs_pkg.sv
// regs_pkg: shared definitions for the integer register file.
//   REG_NUM_DEF / ADDR_W_DEF / DATA_W_DEF : default geometry
//   regs_state_t                          : init-sequencer states
//   REG_ZERO                              : index of the hard-wired zero register
package regs_pkg;

    localparam int REG_NUM_DEF = 32;
    localparam int ADDR_W_DEF  = 5;
    localparam int DATA_W_DEF  = 32;

    localparam int REG_ZERO = 0;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } regs_state_t;

endpackage

// File: rtl/regs_init_ctrl.sv
// regs_init_ctrl: clears the register array one entry per cycle after reset.
//   clk        in  : core clock
//   rst_n      in  : synchronous reset, active HIGH despite the name
//   clr_we_o   out : clear-write enable toward the array
//   clr_addr_o out : entry being cleared this cycle
//   busy_o     out : registered, high while the clear sequence runs
//
//   state | meaning
//   ------+---------------------------------------------
//   INIT  | clearing entry clr_cnt, write-back blocked
//   RUN   | clear finished, normal register file access
module regs_init_ctrl
    import regs_pkg::*;
#(
    parameter int REG_NUM = REG_NUM_DEF,
    parameter int ADDR_W  = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              clr_we_o,
    output logic [ADDR_W-1:0] clr_addr_o,
    output logic              busy_o
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(REG_NUM - 1);

    regs_state_t       state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              busy_q, busy_d;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        busy_d    = busy_q;
        case (state_q)
            INIT: begin
                clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                if (clr_cnt_q == LAST_IDX) begin
                    state_d   = RUN;
                    clr_cnt_d = '0;
                    busy_d    = 1'b0;
                end
            end
            RUN: begin
                busy_d = 1'b0;
            end
            default: begin
                state_d   = INIT;
                clr_cnt_d = '0;
                busy_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q   <= INIT;
            clr_cnt_q <= '0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            busy_q    <= busy_d;
        end
    end

    assign clr_we_o   = (state_q == INIT);
    assign clr_addr_o = clr_cnt_q;
    assign busy_o     = busy_q;

endmodule

// File: rtl/regs.sv
// regs: architectural integer register file, two combinational read ports,
// one write port fed by the write-back stage. Storage has no reset; a
// sequencer zeroes it entry by entry after reset so it can map to RAM.
//   clk, rst_n        : clock, synchronous reset (active HIGH)
//   wb_op_c_i         : write data
//   wb_reg_waddr_i    : write address
//   wb_reg_we_i       : write enable
//   id_reg1/2_raddr_i : read addresses
//   id_reg1/2_rdata_o : read data (combinational)
//   regs_init_busy_o  : high while the clear sequence runs
// Optional macro REGS_BYPASS_EN: forward a same-cycle write to a matching read.
module regs
    import regs_pkg::*;
#(
    parameter int REG_NUM = REG_NUM_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] wb_op_c_i,
    input  logic [ADDR_W-1:0] wb_reg_waddr_i,
    input  logic              wb_reg_we_i,
    input  logic [ADDR_W-1:0] id_reg1_raddr_i,
    output logic [DATA_W-1:0] id_reg1_rdata_o,
    input  logic [ADDR_W-1:0] id_reg2_raddr_i,
    output logic [DATA_W-1:0] id_reg2_rdata_o,
    output logic              regs_init_busy_o
);

    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] regs_mem [REG_NUM];
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              busy;
    logic              wb_wr;

    regs_init_ctrl #(
        .REG_NUM (REG_NUM),
        .ADDR_W  (ADDR_W)
    ) u_init_ctrl (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr),
        .busy_o     (busy)
    );

    // Reset in the same cycle drops the write.
    assign wb_wr = wb_reg_we_i && !busy && !rst_n && (wb_reg_waddr_i != ZERO_IDX);

    always_ff @(posedge clk) begin
        if (clr_we) begin
            regs_mem[clr_addr] <= '0;
        end else if (wb_wr) begin
            regs_mem[wb_reg_waddr_i] <= wb_op_c_i;
        end
    end

    always_comb begin
        id_reg1_rdata_o = '0;
        if (!busy && id_reg1_raddr_i != ZERO_IDX) begin
            id_reg1_rdata_o = regs_mem[id_reg1_raddr_i];
`ifdef REGS_BYPASS_EN
            if (wb_wr && wb_reg_waddr_i == id_reg1_raddr_i) begin
                id_reg1_rdata_o = wb_op_c_i;
            end
`endif
        end
    end

    always_comb begin
        id_reg2_rdata_o = '0;
        if (!busy && id_reg2_raddr_i != ZERO_IDX) begin
            id_reg2_rdata_o = regs_mem[id_reg2_raddr_i];
`ifdef REGS_BYPASS_EN
            if (wb_wr && wb_reg_waddr_i == id_reg2_raddr_i) begin
                id_reg2_rdata_o = wb_op_c_i;
            end
`endif
        end
    end

    assign regs_init_busy_o = busy;

endmodule

// File: tb/tb_regs.sv
module tb_regs;

    localparam int RN = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] wb_op_c_i = '0;
    logic [4:0]  wb_reg_waddr_i = '0;
    logic        wb_reg_we_i = 1'b0;
    logic [4:0]  id_reg1_raddr_i = '0;
    logic [31:0] id_reg1_rdata_o;
    logic [4:0]  id_reg2_raddr_i = '0;
    logic [31:0] id_reg2_rdata_o;
    logic        regs_init_busy_o;

    regs dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .wb_op_c_i        (wb_op_c_i),
        .wb_reg_waddr_i   (wb_reg_waddr_i),
        .wb_reg_we_i      (wb_reg_we_i),
        .id_reg1_raddr_i  (id_reg1_raddr_i),
        .id_reg1_rdata_o  (id_reg1_rdata_o),
        .id_reg2_raddr_i  (id_reg2_raddr_i),
        .id_reg2_rdata_o  (id_reg2_rdata_o),
        .regs_init_busy_o (regs_init_busy_o)
    );

    always #5 clk = ~clk;

    // Reference: architectural contents plus the number of clear cycles left.
    logic [31:0] model [RN];
    int          init_left = 0;
    bit          armed = 1'b0;
    int          total = 0;
    int          passed = 0;
    int          failed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (init_left > 0) return 32'h0;
        if (a == 5'd0) return 32'h0;
`ifdef REGS_BYPASS_EN
        if (!rst_n && wb_reg_we_i && wb_reg_waddr_i == a) return wb_op_c_i;
`endif
        return model[a];
    endfunction

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] r1, input logic [4:0] r2);
        wb_reg_we_i     = we;
        wb_reg_waddr_i  = wa;
        wb_op_c_i       = wd;
        id_reg1_raddr_i = r1;
        id_reg2_raddr_i = r2;
    endtask

    // Check the current cycle's outputs, then advance one clock and update the model.
    task automatic cycle(input string tag);
        #2;
        if (armed) begin
            chk({tag, "/busy"}, {31'b0, regs_init_busy_o}, {31'b0, (init_left > 0)});
            chk({tag, "/rd1"}, id_reg1_rdata_o, exp_rd(id_reg1_raddr_i));
            chk({tag, "/rd2"}, id_reg2_rdata_o, exp_rd(id_reg2_raddr_i));
        end
        @(posedge clk);
        if (rst_n) begin
            init_left = RN;
            foreach (model[i]) model[i] = 32'h0;
            armed = 1'b1;
        end else if (init_left > 0) begin
            init_left--;
        end else if (wb_reg_we_i && wb_reg_waddr_i != 5'd0) begin
            model[wb_reg_waddr_i] = wb_op_c_i;
        end
        #1;
    endtask

    task automatic count_busy(input string tag);
        int n = 0;
        while (regs_init_busy_o === 1'b1 && n < 100) begin
            cycle(tag);
            n++;
        end
        chk({tag, "/len"}, 32'(n), 32'(RN));
    endtask

    initial begin
        foreach (model[i]) model[i] = 32'h0;

        // Power-up reset for two cycles, then the first clear sequence.
        drive(1'b0, 5'd0, 32'h0, 5'd1, 5'd2);
        rst_n = 1'b1;
        cycle("por");
        cycle("por");
        rst_n = 1'b0;
        count_busy("init0");

        // Preload x5, then a one-cycle reset must wipe it.
        drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5);
        cycle("wr5");
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        cycle("rd5");
        chk("x5_pre", id_reg1_rdata_o, 32'hDEADBEEF);
        rst_n = 1'b1;
        cycle("rst1");
        rst_n = 1'b0;
        count_busy("init1");
        #2;
        chk("x5_cleared", id_reg1_rdata_o, 32'h0);

        // Write/read on both ports.
        drive(1'b1, 5'd3, 32'h12345678, 5'd3, 5'd3);
        cycle("wr3");
        drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
        cycle("rd3");
        chk("x3_p1", id_reg1_rdata_o, 32'h12345678);
        chk("x3_p2", id_reg2_rdata_o, 32'h12345678);

        // x0 stays zero in the write cycle and after it.
        drive(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        cycle("wr0");
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        cycle("rd0");
        chk("x0_p1", id_reg1_rdata_o, 32'h0);

        // Same-cycle write/read of x7.
        drive(1'b1, 5'd7, 32'hA5A5A5A5, 5'd3, 5'd7);
        cycle("byp7");
        drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd7);
        cycle("rd7");
        chk("x7_next", id_reg2_rdata_o, 32'hA5A5A5A5);

        // Reset mid-clear at clr_cnt=10, then write attempts during INIT.
        rst_n = 1'b1;
        cycle("rst2");
        rst_n = 1'b0;
        for (int i = 0; i < 10; i++) cycle("init2");
        rst_n = 1'b1;
        cycle("rst3");
        rst_n = 1'b0;
        drive(1'b1, 5'd9, 32'h55, 5'd9, 5'd9);
        count_busy("init3");
        drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
        cycle("rd9");
        chk("x9_zero", id_reg1_rdata_o, 32'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic [4:0] wa;
            wa = 5'($urandom_range(0, 31));
            drive(1'($urandom_range(0, 1)), wa, $urandom(),
                  ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31)));
            cycle("rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
